// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and types for the register-file write-back arbiter
package regfile_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int REG_N  = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {REQ_ALU = 1'b0, REQ_LSU = 1'b1} req_id_e;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, ALU (bit 0) preferred out of reset
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);
    req_id_e r_prio;

    assign o_gnt[0] = i_req[0] & (~i_req[1] | (r_prio == REQ_ALU));
    assign o_gnt[1] = i_req[1] & (~i_req[0] | (r_prio == REQ_LSU));

    // Priority moves to the requester that was not just granted; held when idle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)      r_prio <= REQ_ALU;
        else if (o_gnt[0]) r_prio <= REQ_LSU;
        else if (o_gnt[1]) r_prio <= REQ_ALU;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin write-back scheduler with pending-write scoreboard
// Optional macro REGFILE_WBARB_BYPASS_EN adds forwarding of the committing write to the read ports.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int REG_N  = regfile_pkg::REG_N
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_alu_valid,
    output logic              o_alu_ready,
    input  logic [ADDR_W-1:0] i_alu_addr,
    input  logic [DATA_W-1:0] i_alu_data,
    input  logic              i_lsu_valid,
    output logic              o_lsu_ready,
    input  logic [ADDR_W-1:0] i_lsu_addr,
    input  logic [DATA_W-1:0] i_lsu_data,
    input  logic              i_alloc_en,
    input  logic [ADDR_W-1:0] i_alloc_addr,
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_rs0_addr,
    input  logic [ADDR_W-1:0] i_rs1_addr,
    output logic              o_rs0_busy,
    output logic              o_rs1_busy,
`ifdef REGFILE_WBARB_BYPASS_EN
    output logic              o_rs0_fwd,
    output logic              o_rs1_fwd,
    output logic [DATA_W-1:0] o_fwd_data,
`endif
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data
);
    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [REG_N-1:0]  w_pend_nxt;
    logic [REG_N-1:0]  r_pend;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;

    assign w_req = {i_lsu_valid, i_alu_valid} & {2{~i_flush}};

    rr_arb2 u_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   (w_req),
        .o_gnt   (w_gnt)
    );

    assign o_alu_ready = w_gnt[0];
    assign o_lsu_ready = w_gnt[1];
    assign w_addr      = w_gnt[1] ? i_lsu_addr : i_alu_addr;
    assign w_data      = w_gnt[1] ? i_lsu_data : i_alu_data;

    // Output stage: register the granted write; x0 writes are accepted but never enabled
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= (|w_gnt) & (w_addr != '0);
            if (|w_gnt) begin
                r_wr_addr <= w_addr;
                r_wr_data <= w_data;
            end
        end
    end

    // Scoreboard next state: commit clears, alloc (non-x0) wins over clear, flush wipes all
    always_comb begin
        w_pend_nxt = r_pend;
        if (r_wr_en) w_pend_nxt[r_wr_addr] = 1'b0;
        if (i_alloc_en && (i_alloc_addr != '0)) w_pend_nxt[i_alloc_addr] = 1'b1;
        if (i_flush) w_pend_nxt = '0;
    end

    // Scoreboard register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_pend <= '0;
        else          r_pend <= w_pend_nxt;
    end

    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;

`ifdef REGFILE_WBARB_BYPASS_EN
    assign o_rs0_fwd  = r_wr_en & (r_wr_addr == i_rs0_addr) & (i_rs0_addr != '0);
    assign o_rs1_fwd  = r_wr_en & (r_wr_addr == i_rs1_addr) & (i_rs1_addr != '0);
    assign o_fwd_data = r_wr_data;
    // A same-cycle re-reservation keeps the register busy even while forwarding
    assign o_rs0_busy = r_pend[i_rs0_addr] & (~o_rs0_fwd | (i_alloc_en & (i_alloc_addr == i_rs0_addr)));
    assign o_rs1_busy = r_pend[i_rs1_addr] & (~o_rs1_fwd | (i_alloc_en & (i_alloc_addr == i_rs1_addr)));
`else
    assign o_rs0_busy = r_pend[i_rs0_addr];
    assign o_rs1_busy = r_pend[i_rs1_addr];
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenarios plus random traffic against a behavioural model
module tb_regfile_wb_arbiter;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_alu_valid = 1'b0, i_lsu_valid = 1'b0, i_alloc_en = 1'b0, i_flush = 1'b0;
    logic [4:0]  i_alu_addr = '0, i_lsu_addr = '0, i_alloc_addr = '0, i_rs0_addr = '0, i_rs1_addr = '0;
    logic [31:0] i_alu_data = '0, i_lsu_data = '0;
    logic        o_alu_ready, o_lsu_ready, o_rs0_busy, o_rs1_busy, o_wr_en;
    logic [4:0]  o_wr_addr;
    logic [31:0] o_wr_data;
`ifdef REGFILE_WBARB_BYPASS_EN
    logic        o_rs0_fwd, o_rs1_fwd;
    logic [31:0] o_fwd_data;
`endif

    regfile_wb_arbiter dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready), .i_alu_addr(i_alu_addr), .i_alu_data(i_alu_data),
        .i_lsu_valid(i_lsu_valid), .o_lsu_ready(o_lsu_ready), .i_lsu_addr(i_lsu_addr), .i_lsu_data(i_lsu_data),
        .i_alloc_en(i_alloc_en), .i_alloc_addr(i_alloc_addr), .i_flush(i_flush),
        .i_rs0_addr(i_rs0_addr), .i_rs1_addr(i_rs1_addr), .o_rs0_busy(o_rs0_busy), .o_rs1_busy(o_rs1_busy),
`ifdef REGFILE_WBARB_BYPASS_EN
        .o_rs0_fwd(o_rs0_fwd), .o_rs1_fwd(o_rs1_fwd), .o_fwd_data(o_fwd_data),
`endif
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0, n_err = 0;

    // Reference model: who was granted last, set of reserved registers, write in flight
    int          m_last;
    bit [31:0]   m_pend;
    bit          m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_last = 1;
        m_pend = '0;
        m_wen  = 1'b0;
    endtask

    task automatic cyc(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit lv, input logic [4:0] la, input logic [31:0] ld,
                       input bit al, input logic [4:0] ala, input bit fl,
                       input logic [4:0] r0, input logic [4:0] r1,
                       output bit ga, output bit gl);
        bit b0, b1;
        i_alu_valid = av; i_alu_addr = aa; i_alu_data = ad;
        i_lsu_valid = lv; i_lsu_addr = la; i_lsu_data = ld;
        i_alloc_en = al; i_alloc_addr = ala; i_flush = fl;
        i_rs0_addr = r0; i_rs1_addr = r1;
        @(negedge i_clk);
        ga = av && !fl && (!lv || m_last == 1);
        gl = lv && !fl && (!av || m_last == 0);
        b0 = m_pend[r0];
        b1 = m_pend[r1];
`ifdef REGFILE_WBARB_BYPASS_EN
        begin
            bit f0, f1;
            f0 = m_wen && m_waddr == r0 && r0 != 0;
            f1 = m_wen && m_waddr == r1 && r1 != 0;
            chk("rs0_fwd", o_rs0_fwd, f0);
            chk("rs1_fwd", o_rs1_fwd, f1);
            if (m_wen) chk("fwd_data", o_fwd_data, m_wdata);
            b0 = b0 && (!f0 || (al && ala == r0));
            b1 = b1 && (!f1 || (al && ala == r1));
        end
`endif
        chk("alu_ready", o_alu_ready, ga);
        chk("lsu_ready", o_lsu_ready, gl);
        chk("wr_en", o_wr_en, m_wen);
        if (m_wen) begin
            chk("wr_addr", o_wr_addr, m_waddr);
            chk("wr_data", o_wr_data, m_wdata);
        end
        chk("rs0_busy", o_rs0_busy, b0);
        chk("rs1_busy", o_rs1_busy, b1);
        if (fl) m_pend = '0;
        else begin
            if (m_wen) m_pend[m_waddr] = 1'b0;
            if (al && ala != 0) m_pend[ala] = 1'b1;
        end
        m_wen = 1'b0;
        if (ga || gl) begin
            m_last  = gl ? 1 : 0;
            m_waddr = gl ? la : aa;
            m_wdata = gl ? ld : ad;
            m_wen   = m_waddr != 0;
        end
        @(posedge i_clk);
        #1;
    endtask

    bit          ga, gl;
    bit          a_v, l_v;
    logic [4:0]  a_a, l_a;
    logic [31:0] a_d, l_d;

    initial begin
        model_reset();
        repeat (2) @(negedge i_clk);
        chk("rst_wr_en", o_wr_en, 1'b0);
        chk("rst_wr_addr", o_wr_addr, 5'd0);
        chk("rst_wr_data", o_wr_data, 32'd0);
        chk("rst_alu_ready", o_alu_ready, 1'b0);
        chk("rst_lsu_ready", o_lsu_ready, 1'b0);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        // single ALU write
        cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, ga, gl);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gl);
        // collisions alternate
        cyc(1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0, 0, 0, ga, gl);
        cyc(1, 8, 32'h33, 1, 4, 32'h22, 0, 0, 0, 0, 0, ga, gl);
        cyc(1, 8, 32'h33, 1, 10, 32'h44, 0, 0, 0, 0, 0, ga, gl);
        cyc(0, 0, 0, 1, 10, 32'h44, 0, 0, 0, 0, 0, ga, gl);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gl);
        // reservation held until LSU commits x7
        cyc(0, 0, 0, 0, 0, 0, 1, 7, 0, 7, 0, ga, gl);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, ga, gl);
        cyc(0, 0, 0, 1, 7, 32'h77, 0, 0, 0, 7, 0, ga, gl);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, ga, gl);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, ga, gl);
        // alloc and commit of x9 in the same cycle
        cyc(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 9, ga, gl);
        cyc(0, 0, 0, 1, 9, 32'h99, 0, 0, 0, 0, 9, ga, gl);
        cyc(0, 0, 0, 0, 0, 0, 1, 9, 0, 9, 9, ga, gl);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9, ga, gl);
        // x0 write and x0 alloc
        cyc(1, 0, 32'h55, 0, 0, 0, 1, 0, 0, 0, 0, ga, gl);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gl);
        // flush wipes reservations and blocks grants
        cyc(0, 0, 0, 0, 0, 0, 1, 2, 0, 2, 6, ga, gl);
        cyc(0, 0, 0, 0, 0, 0, 1, 6, 0, 2, 6, ga, gl);
        cyc(0, 0, 0, 1, 12, 32'hAA, 1, 3, 1, 2, 6, ga, gl);
        cyc(0, 0, 0, 1, 12, 32'hAA, 0, 0, 0, 2, 6, ga, gl);
        // random traffic; requesters hold until granted
        a_v = 0; l_v = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!a_v && $urandom_range(1, 0) == 1) begin
                a_v = 1; a_a = 5'($urandom_range(7, 0)); a_d = $urandom;
            end
            if (!l_v && $urandom_range(1, 0) == 1) begin
                l_v = 1; l_a = 5'($urandom_range(7, 0)); l_d = $urandom;
            end
            cyc(a_v, a_a, a_d, l_v, l_a, l_d, $urandom_range(2, 0) == 0, 5'($urandom_range(7, 0)),
                $urandom_range(15, 0) == 0, 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)), ga, gl);
            if (ga) a_v = 0;
            if (gl) l_v = 0;
        end
        // asynchronous reset while a write is in the output stage
        cyc(1, 5, 32'h12345678, 0, 0, 0, 1, 11, 0, 0, 0, ga, gl);
        i_alu_valid = 0; i_alloc_en = 0; i_rs0_addr = 11;
        chk("wen_before_rst", o_wr_en, 1'b1);
        i_rst_n = 1'b0;
        #1;
        chk("wen_async_rst", o_wr_en, 1'b0);
        chk("addr_async_rst", o_wr_addr, 5'd0);
        chk("busy_async_rst", o_rs0_busy, 1'b0);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        model_reset();
        cyc(1, 13, 32'hCAFE, 1, 14, 32'hBEEF, 0, 0, 0, 0, 0, ga, gl);
        cyc(0, 0, 0, 1, 14, 32'hBEEF, 0, 0, 0, 0, 0, ga, gl);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gl);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
